// File: rtl/pc_sequencer_pkg.sv
// Core-wide next-PC select and opcode constants.
// The PC control logic uses these same values.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_JMP = 2'd1,
    PCSRC_BR  = 2'd2,
    PCSRC_RET = 2'd3
  } pcsrc_e;

  localparam logic [5:0] OP_JMP  = 6'd12;
  localparam logic [5:0] OP_CALL = 6'd13;
  localparam logic [5:0] OP_RET  = 6'd14;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address stack: the stack pointer and the entry array.
// A push while full or a pop while empty is dropped and flagged for one cycle.
module return_stack #(
  parameter int PC_W     = 32,
  parameter int RS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [PC_W-1:0]  entry_q [RS_DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_W'(RS_DEPTH));
  assign ovf     = push & full;
  assign unf     = pop & empty;
  assign wr_idx  = sp_q[IDX_W-1:0];
  // sp == RS_DEPTH has zero low bits, so sp-1 still lands on the last entry.
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign top     = entry_q[top_idx];

  always_comb begin
    sp_d  = sp_q;
    wr_en = 1'b0;
    if (push && !full) begin
      sp_d  = sp_q + SP_W'(1);
      wr_en = 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) entry_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register, next-PC mux and sticky return-stack error flag.
// All state advances only on pc_write cycles.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              RS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic [1:0]      pcsrc,
  input  logic [5:0]      opcode,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic [PC_W-1:0] rs_top,
  output logic            rs_empty,
  output logic            rs_full,
  output logic            rs_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            push, pop, ovf, unf;

  assign push = pc_write && (pcsrc == PCSRC_JMP) && (opcode == OP_CALL);
  assign pop  = pc_write && (pcsrc == PCSRC_RET);

  return_stack #(
    .PC_W     (PC_W),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (rs_top),
    .empty     (rs_empty),
    .full      (rs_full),
    .ovf       (ovf),
    .unf       (unf)
  );

  assign pc_plus1 = pc_q + PC_W'(1);

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q | ovf | unf;
    if (pc_write) begin
      case (pcsrc)
        PCSRC_SEQ: pc_d = pc_plus1;
        PCSRC_JMP: pc_d = jump_target;
        PCSRC_BR:  pc_d = pc_q + branch_offset;
        default:   pc_d = unf ? RESET_PC : rs_top;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc     = pc_q;
  assign rs_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer with hand-written reset, hold and
// stack-overflow sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pcsrc = 2'd0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] jump_target = '0;
  logic [31:0] branch_offset = '0;
  logic [31:0] pc, pc_plus1, rs_top;
  logic        rs_empty, rs_full, rs_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .pcsrc         (pcsrc),
    .opcode        (opcode),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .rs_top        (rs_top),
    .rs_empty      (rs_empty),
    .rs_full       (rs_full),
    .rs_err        (rs_err)
  );

  typedef struct {
    logic        pw;
    logic [1:0]  src;
    logic [5:0]  op;
    logic [31:0] tgt;
    logic [31:0] off;
    logic [31:0] e_pc;
    logic [31:0] e_top;
    logic        e_empty;
    logic        e_full;
    logic        e_err;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [1:0] src, logic [5:0] op, logic [31:0] tgt,
                              logic [31:0] off, logic [31:0] e_pc, logic [31:0] e_top,
                              logic e_empty, logic e_err);
    vec_t v;
    v.pw = 1'b1; v.src = src; v.op = op; v.tgt = tgt; v.off = off;
    v.e_pc = e_pc; v.e_top = e_top; v.e_empty = e_empty; v.e_full = 1'b0; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(logic pw, logic [1:0] src, logic [5:0] op,
                       logic [31:0] tgt, logic [31:0] off);
    @(negedge clk);
    pc_write = pw; pcsrc = src; opcode = op; jump_target = tgt; branch_offset = off;
    @(posedge clk);
    #1;
    pc_write = 1'b0;
  endtask

  task automatic check_state(string tag, logic [31:0] e_pc, logic [31:0] e_top,
                             logic chk_top, logic e_empty, logic e_full, logic e_err);
    chk32({tag, ".pc"}, pc, e_pc);
    chk32({tag, ".pc_plus1"}, pc_plus1, e_pc + 32'd1);
    if (chk_top) chk32({tag, ".rs_top"}, rs_top, e_top);
    chk1({tag, ".rs_empty"}, rs_empty, e_empty);
    chk1({tag, ".rs_full"}, rs_full, e_full);
    chk1({tag, ".rs_err"}, rs_err, e_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] pushed[9];

  initial begin
    // Path from reset: jumps set up pc=0x10, wrap at all-ones, nested CALL/RET,
    // underflow, then a CALL/RET pair on consecutive cycles.
    tbl[0]  = mk(2'd1, 6'd12, 32'h10,       32'h0,        32'h10,       32'h0,   1, 0);
    tbl[1]  = mk(2'd2, 6'd0,  32'h0,        32'hFFFFFFFC, 32'h0C,       32'h0,   1, 0);
    tbl[2]  = mk(2'd1, 6'd12, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0,   1, 0);
    tbl[3]  = mk(2'd0, 6'd0,  32'h0,        32'h0,        32'h0,        32'h0,   1, 0);
    tbl[4]  = mk(2'd1, 6'd12, 32'h20,       32'h0,        32'h20,       32'h0,   1, 0);
    tbl[5]  = mk(2'd1, 6'd13, 32'h100,      32'h0,        32'h100,      32'h21,  0, 0);
    tbl[6]  = mk(2'd1, 6'd12, 32'h105,      32'h0,        32'h105,      32'h21,  0, 0);
    tbl[7]  = mk(2'd1, 6'd13, 32'h200,      32'h0,        32'h200,      32'h106, 0, 0);
    tbl[8]  = mk(2'd3, 6'd0,  32'h0,        32'h0,        32'h106,      32'h21,  0, 0);
    tbl[9]  = mk(2'd3, 6'd14, 32'h0,        32'h0,        32'h21,       32'h0,   1, 0);
    tbl[10] = mk(2'd3, 6'd14, 32'h0,        32'h0,        32'h0,        32'h0,   1, 1);
    tbl[11] = mk(2'd2, 6'd0,  32'h0,        32'h5,        32'h5,        32'h0,   1, 1);
    tbl[12] = mk(2'd1, 6'd13, 32'h40,       32'h0,        32'h40,       32'h6,   0, 1);
    tbl[13] = mk(2'd3, 6'd14, 32'h0,        32'h0,        32'h6,        32'h0,   1, 1);

    #12;
    check_state("reset", 32'h0, 32'h0, 0, 1, 0, 0);
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      drive(1, 2'd0, 6'd0, 32'h0, 32'h0);
      check_state($sformatf("seq%0d", i), 32'(i), 32'h0, 0, 1, 0, 0);
    end
    drive(1, 2'd1, 6'd13, 32'h50, 32'h0);
    check_state("call_pre_rst", 32'h50, 32'h4, 1, 0, 0, 0);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].pw, tbl[i].src, tbl[i].op, tbl[i].tgt, tbl[i].off);
      check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_top,
                  !tbl[i].e_empty, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_err);
    end

    drive(1, 2'd1, 6'd13, 32'h300, 32'h0);
    check_state("call_before_hold", 32'h300, 32'h7, 1, 0, 0, 1);
    @(negedge clk);
    pc_write = 1'b0; pcsrc = 2'd3; opcode = 6'd13; jump_target = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_state($sformatf("hold%0d", c), 32'h300, 32'h7, 1, 0, 0, 1);
    end

    do_reset();
    check_state("reset2", 32'h0, 32'h0, 0, 1, 0, 0);
    exp_pc = 32'h0;
    for (int k = 0; k < 9; k++) begin
      pushed[k] = exp_pc + 32'd1;
      drive(1, 2'd1, 6'd13, 32'h1000 + 32'(k) * 32'h10, 32'h0);
      exp_pc = 32'h1000 + 32'(k) * 32'h10;
      if (k < 8)
        check_state($sformatf("call%0d", k), exp_pc, pushed[k], 1, 0, k == 7, 0);
      else
        check_state("call_ovf", exp_pc, pushed[7], 1, 0, 1, 1);
    end
    for (int j = 7; j >= 0; j--) begin
      drive(1, 2'd3, 6'd14, 32'h0, 32'h0);
      chk32($sformatf("ret%0d.pc", j), pc, pushed[j]);
      chk1($sformatf("ret%0d.empty", j), rs_empty, j == 0);
      chk1($sformatf("ret%0d.full", j), rs_full, 1'b0);
      chk1($sformatf("ret%0d.err", j), rs_err, 1'b1);
      if (j > 0) chk32($sformatf("ret%0d.top", j), rs_top, pushed[j-1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
